// File: rtl/ad80305_rx_bist.sv
// ---------------------------------------------------------------------------
// ad80305_rx_bist
//
// Built-in self-test for the AD80305 12-bit LVCMOS DDR RX path.
//
//  * Generator: emulates the transceiver RX port as an SDR word stream. One
//    I/Q sample takes four cycles. Slots 0-1 carry I with frame=1, and slots
//    2-3 carry Q with frame=0. The output can feed ODDR/loopback pins in place
//    of the chip.
//  * Checker: consumes the de-framed I/Q samples recovered by the RX
//    interface. It locks onto the selected pattern and counts mismatches.
//
// Patterns (i_mode): 0 ramp, 1 PRBS12, 2 constant, 3 alternating 555/AAA.
//
// Parameters
//   LOCK_CNT  consecutive matching samples needed to go from SYNC to LOCKED
//   ERR_W     width of the saturating error counter
//
// Ports
//   i_fpga_clk, i_fpga_rst_n   clock, asynchronous active-low reset
//   i_enable                   run; 0 holds generator and checker in reset state
//   i_mode                     pattern select
//   i_const_i, i_const_q       values for constant mode
//   i_clr_err                  synchronous clear of o_err_cnt
//   i_err_inj                  (optional) flip bit 0 of the next I word
//   o_tx_frame, o_tx_data      emulated RX_FRAME / RX_DATA
//   i_chk_fp                   recovered-sample strobe, one cycle per I/Q pair
//   i_chk_idata, i_chk_qdata   recovered I/Q
//   o_lock                     checker is LOCKED
//   o_err_cnt                  saturating mismatch count, counted only in LOCKED
//   o_err_pulse                one-cycle pulse per mismatch in LOCKED
//
// Build option
//   AD80305_BIST_ERR_INJ_EN    adds i_err_inj and the injection logic
// ---------------------------------------------------------------------------
module ad80305_rx_bist #(
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 16
) (
  input  logic             i_fpga_clk,
  input  logic             i_fpga_rst_n,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [11:0]      i_const_i,
  input  logic [11:0]      i_const_q,
  input  logic             i_clr_err,
`ifdef AD80305_BIST_ERR_INJ_EN
  input  logic             i_err_inj,
`endif
  output logic             o_tx_frame,
  output logic [11:0]      o_tx_data,
  input  logic             i_chk_fp,
  input  logic [11:0]      i_chk_idata,
  input  logic [11:0]      i_chk_qdata,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_err_pulse
);

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int                  MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [MATCH_W-1:0]  LOCK_LAST = MATCH_W'(LOCK_CNT - 1);

  // x^12+x^11+x^10+x^4+1, Fibonacci form, shifting left.
  function automatic logic [11:0] lfsr_next(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[10] ^ v[9] ^ v[3]};
  endfunction

  mode_e       w_mode;
  logic        w_restart;

  // Generator state
  logic [1:0]  r_mode_q;
  logic [1:0]  r_slot;
  logic [11:0] r_ramp;
  logic [11:0] r_lfsr;
  logic [11:0] r_alt;
  logic [11:0] r_const_i;
  logic [11:0] r_const_q;
  logic [11:0] w_gen_i;
  logic [11:0] w_gen_q;
  logic        w_inj_now;

  // Checker state
  state_e             r_state;
  state_e             w_state_nxt;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [1:0]         r_miss_cnt;
  logic [1:0]         w_miss_nxt;
  logic [11:0]        r_ref;
  logic [11:0]        w_exp_i;
  logic [11:0]        w_exp_q;
  logic               w_match;
  logic               w_err_hit;

  assign w_mode = mode_e'(i_mode);

  // Disabling or switching pattern restarts both halves from their seed state.
  // The mode compare uses the previous cycle's mode, so a switch costs one
  // idle word before the new pattern starts at slot 0.
  assign w_restart = !i_enable || (i_mode != r_mode_q);

  // ------------------------------------------------------------------------
  // Generator
  // ------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gen_i = r_ramp;
    w_gen_q = ~r_ramp;
    case (w_mode)
      MODE_PRBS: begin
        w_gen_i = r_lfsr;
        w_gen_q = ~r_lfsr;
      end
      MODE_CONST: begin
        // The constants are sampled at slot 0. Slot 0 passes the live value,
        // and later slots reuse the captured copy.
        w_gen_i = (r_slot == 2'd0) ? i_const_i : r_const_i;
        w_gen_q = r_const_q;
      end
      MODE_ALT: begin
        w_gen_i = r_alt;
        w_gen_q = ~r_alt;
      end
      default: ;
    endcase
  end

`ifdef AD80305_BIST_ERR_INJ_EN
  // A pulse corrupts both copies (slots 0 and 1) of the next I word. Pulses
  // that arrive while an injection is still pending merge into it.
  logic r_inj_pend;
  logic r_inj_act;

  always_ff @(posedge i_fpga_clk or negedge i_fpga_rst_n) begin
    if (!i_fpga_rst_n) begin
      r_inj_pend <= 1'b0;
      r_inj_act  <= 1'b0;
    end else if (!w_restart && r_slot == 2'd0) begin
      r_inj_act  <= r_inj_pend | i_err_inj;
      r_inj_pend <= 1'b0;
    end else if (i_err_inj) begin
      r_inj_pend <= 1'b1;
    end
  end

  assign w_inj_now = (r_slot == 2'd0) ? (r_inj_pend | i_err_inj)
                                      : ((r_slot == 2'd1) && r_inj_act);
`else
  assign w_inj_now = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge i_fpga_clk or negedge i_fpga_rst_n) begin
    if (!i_fpga_rst_n) begin
      r_mode_q   <= 2'd0;
      r_slot     <= 2'd0;
      r_ramp     <= 12'h000;
      r_lfsr     <= 12'h001;
      r_alt      <= 12'h555;
      r_const_i  <= 12'h000;
      r_const_q  <= 12'h000;
      o_tx_frame <= 1'b0;
      o_tx_data  <= 12'h000;
    end else begin
      r_mode_q <= i_mode;
      if (w_restart) begin
        r_slot     <= 2'd0;
        r_ramp     <= 12'h000;
        r_lfsr     <= 12'h001;
        r_alt      <= 12'h555;
        o_tx_frame <= 1'b0;
        o_tx_data  <= 12'h000;
      end else begin
        r_slot     <= r_slot + 2'd1;
        o_tx_frame <= ~r_slot[1];
        o_tx_data  <= r_slot[1] ? w_gen_q : (w_gen_i ^ {11'd0, w_inj_now});
        if (r_slot == 2'd0) begin
          r_const_i <= i_const_i;
          r_const_q <= i_const_q;
        end
        // Pattern state advances once per sample, at the end of slot 3.
        if (r_slot == 2'd3) begin
          r_ramp <= r_ramp + 12'd1;
          r_lfsr <= lfsr_next(r_lfsr);
          r_alt  <= ~r_alt;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Checker
  // ------------------------------------------------------------------------
  // The expected sample is derived from the previously received I, so the
  // checker resynchronises to any phase of the pattern.
  always_comb begin
    w_exp_i = r_ref + 12'd1;
    case (w_mode)
      MODE_PRBS:  w_exp_i = lfsr_next(r_ref);
      MODE_CONST: w_exp_i = i_const_i;
      MODE_ALT:   w_exp_i = ~r_ref;
      default:    ;
    endcase
    w_exp_q = (w_mode == MODE_CONST) ? i_const_q : ~w_exp_i;
    // A PRBS reference of 0 would predict 0 forever, so 0 is never a match.
    w_match = (i_chk_idata == w_exp_i) && (i_chk_qdata == w_exp_q) &&
              !((w_mode == MODE_PRBS) && (i_chk_idata == 12'h000));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err_hit   = 1'b0;
    if (w_restart) begin
      w_state_nxt = ST_HUNT;
      w_match_nxt = '0;
      w_miss_nxt  = 2'd0;
    end else if (i_chk_fp) begin
      case (r_state)
        ST_HUNT: begin
          w_state_nxt = ST_SYNC;
          w_match_nxt = '0;
          w_miss_nxt  = 2'd0;
        end
        ST_SYNC: begin
          if (!w_match) begin
            w_state_nxt = ST_HUNT;
          end else if (r_match_cnt == LOCK_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = 2'd0;
          end else begin
            w_match_nxt = r_match_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_miss_nxt = 2'd0;
          end else begin
            w_err_hit = 1'b1;
            if (r_miss_cnt == 2'd3) begin
              w_state_nxt = ST_HUNT;
              w_miss_nxt  = 2'd0;
            end else begin
              w_miss_nxt = r_miss_cnt + 2'd1;
            end
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_fpga_clk or negedge i_fpga_rst_n) begin
    if (!i_fpga_rst_n) begin
      r_state     <= ST_HUNT;
      r_match_cnt <= '0;
      r_miss_cnt  <= 2'd0;
      r_ref       <= 12'h000;
      o_err_cnt   <= '0;
      o_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      o_err_pulse <= w_err_hit;
      if (!w_restart && i_chk_fp) r_ref <= i_chk_idata;
      // A clear wins over a simultaneous mismatch.
      if (i_clr_err)
        o_err_cnt <= '0;
      else if (w_err_hit && (o_err_cnt != {ERR_W{1'b1}}))
        o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

  assign o_lock = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_ad80305_rx_bist.sv
// ---------------------------------------------------------------------------
// tb_ad80305_rx_bist
//
// The bench closes the loop from o_tx_* back into i_chk_* with a small model
// of the RX interface: it holds the I word and strobes when the frame falls.
// A reference generator pushes the expected word for every clock into a
// scoreboard, and that word is popped and compared against the DUT output.
// The recovery path can corrupt Q of chosen samples to exercise the checker.
// ERR_W is reduced to 4 so that saturation is reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad80305_rx_bist;

  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [11:0]      ci, cq;
  logic             clr;
  logic             tx_frame;
  logic [11:0]      tx_data;
  logic             chk_fp;
  logic [11:0]      chk_i, chk_q;
  logic             lock;
  logic [ERR_W-1:0] err_cnt;
  logic             err_pulse;
`ifdef AD80305_BIST_ERR_INJ_EN
  logic             err_inj;
`endif

  always #4 clk = ~clk;

  ad80305_rx_bist #(.LOCK_CNT(8), .ERR_W(ERR_W)) dut (
    .i_fpga_clk   (clk),
    .i_fpga_rst_n (rst_n),
    .i_enable     (en),
    .i_mode       (mode),
    .i_const_i    (ci),
    .i_const_q    (cq),
    .i_clr_err    (clr),
`ifdef AD80305_BIST_ERR_INJ_EN
    .i_err_inj    (err_inj),
`endif
    .o_tx_frame   (tx_frame),
    .o_tx_data    (tx_data),
    .i_chk_fp     (chk_fp),
    .i_chk_idata  (chk_i),
    .i_chk_qdata  (chk_q),
    .o_lock       (lock),
    .o_err_cnt    (err_cnt),
    .o_err_pulse  (err_pulse)
  );

  typedef struct packed {
    logic        frame;
    logic [11:0] data;
  } word_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  word_t       sb_q[$];
  logic        sb_on = 1'b1;
  word_t       tx_log[$];
  logic [11:0] rx_log[$];
  logic        corrupt_seq[$];
  logic        clr_with_corrupt = 1'b0;
  int          strobes = 0;
  int          pulses  = 0;

  // Reference generator state
  int          m_slot = 0;
  logic [11:0] m_pat  = 12'h000;
  logic        m_restart = 1'b0;
  logic        lb_prev_frame = 1'b0;
  logic [11:0] lb_i = 12'h000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_seed(input logic [1:0] md);
    case (md)
      2'd1:    return 12'h001;
      2'd3:    return 12'h555;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] m_adv(input logic [1:0] md, input logic [11:0] p);
    case (md)
      2'd0:    return p + 12'd1;
      2'd1:    return {p[10:0], p[11] ^ p[10] ^ p[9] ^ p[3]};
      2'd3:    return ~p;
      default: return p;
    endcase
  endfunction

  // One clock: predict, wait for the edge, compare, then act as the RX interface.
  task automatic step();
    word_t e;
    word_t got;
    logic  was_fp;
    if (!en || m_restart) begin
      e         = '0;
      m_slot    = 0;
      m_pat     = m_seed(mode);
      m_restart = 1'b0;
    end else begin
      if (m_slot < 2) e = {1'b1, (mode == 2'd2) ? ci : m_pat};
      else            e = {1'b0, (mode == 2'd2) ? cq : ~m_pat};
      if (m_slot == 3) m_pat = m_adv(mode, m_pat);
      m_slot = (m_slot + 1) % 4;
    end
    sb_q.push_back(e);
    was_fp = chk_fp;
    @(posedge clk);
    #1;
    if (was_fp) strobes++;
    if (err_pulse) pulses++;
    got = {tx_frame, tx_data};
    e   = sb_q.pop_front();
    if (sb_on) check("tx_word", 32'(got), 32'(e));
    if (tx_log.size() < 8) tx_log.push_back(got);
    clr    = 1'b0;
    chk_fp = 1'b0;
    if (tx_frame) begin
      lb_i = tx_data;
    end else if (lb_prev_frame) begin
      chk_fp = 1'b1;
      chk_i  = lb_i;
      chk_q  = tx_data;
      rx_log.push_back(lb_i);
      if (corrupt_seq.size() > 0) begin
        if (corrupt_seq.pop_front()) begin
          chk_q = chk_q ^ 12'h001;
          if (clr_with_corrupt) begin
            clr = 1'b1;
            clr_with_corrupt = 1'b0;
          end
        end
      end
    end
    lb_prev_frame = tx_frame;
  endtask

  task automatic run_strobes(input int n);
    int target = strobes + n;
    int budget = n * 4 + 16;
    while (strobes < target && budget > 0) begin
      step();
      budget--;
    end
    if (strobes < target) check("strobe_timeout", 32'(strobes), 32'(target));
  endtask

  task automatic run_until_lock(input string tag, input int max_strobes);
    int target = strobes + max_strobes;
    int budget = max_strobes * 4 + 16;
    while (!lock && strobes < target && budget > 0) begin
      step();
      budget--;
    end
    check(tag, 32'(lock), 32'd1);
  endtask

  // Leave no strobe pending, so that queued corruptions hit the next sample.
  task automatic align();
    while (chk_fp) step();
  endtask

  task automatic set_mode(input logic [1:0] md);
    if (md != mode) m_restart = 1'b1;
    mode = md;
  endtask

  task automatic switch_clean(input logic [1:0] md);
    en = 1'b0;
    repeat (3) step();
    set_mode(md);
    step();
    rx_log.delete();
    en = 1'b1;
  endtask

  task automatic clear_errs();
    clr = 1'b1;
    step();
    check("err_cleared", 32'(err_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t exp_tbl[8];
    logic [11:0] prbs_tbl[4];
    int zeros;
    int e0;
`ifdef AD80305_BIST_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    rst_n  = 1'b0;
    en     = 1'b1;
    mode   = 2'd0;
    ci     = 12'h123;
    cq     = 12'hABC;
    clr    = 1'b0;
    chk_fp = 1'b0;
    chk_i  = 12'h000;
    chk_q  = 12'h000;
    #20;
    check("rst_frame", 32'(tx_frame), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    #2 rst_n = 1'b1;

    // Ramp loopback: lock after exactly 9 strobes, then long clean run across wraps.
    run_strobes(8);
    check("ramp_not_locked_8", 32'(lock), 32'd0);
    run_strobes(1);
    check("ramp_locked_9", 32'(lock), 32'd1);
    exp_tbl = '{13'h1000, 13'h1000, 13'h0FFF, 13'h0FFF,
                13'h1001, 13'h1001, 13'h0FFE, 13'h0FFE};
    for (int i = 0; i < 8; i++) check("ramp_first_words", 32'(tx_log[i]), 32'(exp_tbl[i]));
    run_strobes(9991);
    check("ramp_err_cnt", 32'(err_cnt), 32'd0);
    check("ramp_pulses", 32'(pulses), 32'd0);
    check("ramp_lock_held", 32'(lock), 32'd1);

    // Loss of sync: four corrupted samples in a row.
    align();
    pulses = 0;
    repeat (4) corrupt_seq.push_back(1'b1);
    run_strobes(4);
    check("los_err_cnt", 32'(err_cnt), 32'd4);
    check("los_pulses", 32'(pulses), 32'd4);
    check("los_unlocked", 32'(lock), 32'd0);
    run_strobes(8);
    check("relock_not_yet", 32'(lock), 32'd0);
    run_strobes(1);
    check("relock_9", 32'(lock), 32'd1);

    // Saturation: 21 mismatches, never four in a row, so lock is kept.
    clear_errs();
    align();
    for (int k = 0; k < 28; k++) corrupt_seq.push_back((k % 4) != 3);
    run_strobes(28);
    check("sat_err_cnt", 32'(err_cnt), 32'hF);
    check("sat_lock", 32'(lock), 32'd1);
    align();
    corrupt_seq.push_back(1'b1);
    clr_with_corrupt = 1'b1;
    run_strobes(1);
    check("clr_beats_err", 32'(err_cnt), 32'd0);
    run_strobes(1);
    check("clr_stays", 32'(err_cnt), 32'd0);

    // Mode switch from ramp to constant in the middle of a sample.
    while (!tx_frame) step();
    set_mode(2'd2);
    step();
    step();
    check("modesw_unlocked", 32'(lock), 32'd0);
    run_until_lock("modesw_relock", 12);
    check("modesw_err_cnt", 32'(err_cnt), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    check("arst_frame", 32'(tx_frame), 32'd0);
    check("arst_data", 32'(tx_data), 32'd0);
    check("arst_lock", 32'(lock), 32'd0);
    m_slot = 0;
    m_pat = m_seed(mode);
    m_restart = (mode != 2'd0);
    lb_prev_frame = 1'b0;
    chk_fp = 1'b0;
    #2 rst_n = 1'b1;
    step();
    step();
    check("arst_first_i", 32'({tx_frame, tx_data}), 32'h1123);
    run_until_lock("arst_relock", 12);

    // PRBS12: first words, period 4095, never zero.
    clear_errs();
    switch_clean(2'd1);
    run_until_lock("prbs_lock", 12);
    run_strobes(4100 - rx_log.size());
    prbs_tbl = '{12'h001, 12'h002, 12'h004, 12'h008};
    for (int i = 0; i < 4; i++) check("prbs_first_i", 32'(rx_log[i]), 32'(prbs_tbl[i]));
    check("prbs_period_0", 32'(rx_log[4095]), 32'h001);
    check("prbs_period_1", 32'(rx_log[4096]), 32'h002);
    zeros = 0;
    foreach (rx_log[i]) if (rx_log[i] == 12'h000) zeros++;
    check("prbs_no_zero", 32'(zeros), 32'd0);
    check("prbs_err_cnt", 32'(err_cnt), 32'd0);
    check("prbs_lock", 32'(lock), 32'd1);

    // Alternating pattern.
    switch_clean(2'd3);
    run_until_lock("alt_lock", 12);
    check("alt_first_i", 32'(rx_log[0]), 32'h555);
    check("alt_second_i", 32'(rx_log[1]), 32'hAAA);
    run_strobes(20);
    check("alt_err_cnt", 32'(err_cnt), 32'd0);

`ifdef AD80305_BIST_ERR_INJ_EN
    // Error injection in constant mode: exactly one bad sample.
    switch_clean(2'd2);
    run_until_lock("inj_lock", 12);
    clear_errs();
    pulses = 0;
    sb_on = 1'b0;
    err_inj = 1'b1;
    step();
    err_inj = 1'b0;
    run_strobes(6);
    sb_on = 1'b1;
    check("inj_pulses", 32'(pulses), 32'd1);
    check("inj_err_cnt", 32'(err_cnt), 32'd1);
    check("inj_lock", 32'(lock), 32'd1);
`endif

    // Disable holds the checker in reset but keeps the error count.
    align();
    corrupt_seq.push_back(1'b1);
    run_strobes(1);
    e0 = int'(err_cnt);
    en = 1'b0;
    step();
    step();
    check("dis_unlocked", 32'(lock), 32'd0);
    check("dis_err_kept", 32'(err_cnt), 32'(e0));
    check("dis_tx_idle", 32'({tx_frame, tx_data}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
